// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_pkg;
  localparam int DIV_W = 8;
  localparam int CNT_W = $clog2(DIV_W);
  localparam logic [6:0] SEG_ZERO = 7'h40;

  typedef enum logic [2:0] {IDLE, CAPTURE, ITER, FIX, HOLD} div_state_t;
endpackage

// File: rtl/divider_if.sv
// Lab I/O bundle for the divider: switches, buttons, register LEDs and hex digits.
interface divider_if import divider_pkg::*; #(parameter int WIDTH = DIV_W) ();
  logic             clear_a_load_b;
  logic             run;
  logic [WIDTH-1:0] sw;
  logic             x;
  logic [WIDTH-1:0] aval;
  logic [WIDTH-1:0] bval;
  logic [6:0]       ahex_u;
  logic [6:0]       ahex_l;
  logic [6:0]       bhex_u;
  logic [6:0]       bhex_l;

  modport master (output clear_a_load_b, run, sw,
                  input  x, aval, bval, ahex_u, ahex_l, bhex_u, bhex_l);
  modport slave  (input  clear_a_load_b, run, sw,
                  output x, aval, bval, ahex_u, ahex_l, bhex_u, bhex_l);
endinterface

// File: rtl/HexDriver.sv
// Nibble to active-low seven-segment glyph decoder.
module HexDriver (
  input  logic [3:0] in_i,
  output logic [6:0] out_o
);
  always_comb begin
    out_o = 7'h7F;
    case (in_i)
      4'h0: out_o = 7'h40;
      4'h1: out_o = 7'h79;
      4'h2: out_o = 7'h24;
      4'h3: out_o = 7'h30;
      4'h4: out_o = 7'h19;
      4'h5: out_o = 7'h12;
      4'h6: out_o = 7'h02;
      4'h7: out_o = 7'h78;
      4'h8: out_o = 7'h00;
      4'h9: out_o = 7'h10;
      4'hA: out_o = 7'h08;
      4'hB: out_o = 7'h03;
      4'hC: out_o = 7'h46;
      4'hD: out_o = 7'h21;
      4'hE: out_o = 7'h06;
      default: out_o = 7'h0E;
    endcase
  end
endmodule

// File: rtl/divider_control.sv
// Divider sequencer: state register, next-state logic and iteration counter.
//   state   | meaning
//   IDLE    | wait for load or run
//   CAPTURE | latch divisor, detect error cases
//   ITER    | one quotient bit per cycle
//   FIX     | apply result signs (signed build only)
//   HOLD    | results held until run drops
module divider_control import divider_pkg::*; #(
  parameter int WIDTH = DIV_W,
  parameter int CW    = CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic ld_i,
  input  logic cap_err_i,
  output logic ld_b_o,
  output logic capture_o,
  output logic shift_sub_o,
  output logic fix_o
);
  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_CAPTURE = CAPTURE;
  localparam logic [2:0] S_ITER    = ITER;
  localparam logic [2:0] S_FIX     = FIX;
  localparam logic [2:0] S_HOLD    = HOLD;
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
`ifdef DIVIDER_SIGNED_EN
  localparam logic [2:0] S_POST    = S_FIX;
`else
  localparam logic [2:0] S_POST    = S_HOLD;
`endif

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ld_b_o      = 1'b0;
    capture_o   = 1'b0;
    shift_sub_o = 1'b0;
    fix_o       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ld_i)       ld_b_o  = 1'b1;
        else if (run_i) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        capture_o = 1'b1;
        cnt_d     = '0;
        state_d   = cap_err_i ? S_HOLD : S_ITER;
      end
      S_ITER: begin
        shift_sub_o = 1'b1;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_POST;
      end
      S_FIX: begin
        fix_o   = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: if (!run_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/divider.sv
// Sequential restoring divider top: A=remainder, B=dividend/quotient, D=divisor.
// Define DIVIDER_SIGNED_EN for two's-complement operands.
module divider import divider_pkg::*; #(parameter int WIDTH = DIV_W) (
  input  logic     clk,
  input  logic     rst,
  divider_if.slave bus
);
  logic             ld_b, capture, shift_sub, fix, cap_err;
  logic             x_q, ge;
  logic [WIDTH-1:0] a_q, b_q, d_q;
  logic [WIDTH-1:0] cap_a, cap_b, cap_d, fix_a, fix_b, a_sub;
  logic [WIDTH:0]   t;
  logic [6:0]       ahex_u, ahex_l, bhex_u, bhex_l;

  divider_control #(.WIDTH(WIDTH), .CW($clog2(WIDTH))) u_ctrl (
    .clk(clk), .rst(rst), .run_i(bus.run), .ld_i(bus.clear_a_load_b),
    .cap_err_i(cap_err), .ld_b_o(ld_b), .capture_o(capture),
    .shift_sub_o(shift_sub), .fix_o(fix)
  );

  assign t     = {a_q, b_q[WIDTH-1]};
  assign ge    = t >= {1'b0, d_q};
  assign a_sub = t[WIDTH-1:0] - d_q;

`ifdef DIVIDER_SIGNED_EN
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic b_neg, d_neg, dz, ovf, q_neg_q, r_neg_q;
  assign b_neg   = b_q[WIDTH-1];
  assign d_neg   = bus.sw[WIDTH-1];
  assign dz      = bus.sw == '0;
  assign ovf     = (b_q == MIN_NEG) && (bus.sw == '1);
  assign cap_err = dz | ovf;
  assign cap_d   = d_neg ? -bus.sw : bus.sw;
  assign cap_a   = dz ? b_q : '0;
  assign cap_b   = dz ? '1 : (ovf ? MIN_NEG : (b_neg ? -b_q : b_q));
  assign fix_a   = r_neg_q ? -a_q : a_q;
  assign fix_b   = q_neg_q ? -b_q : b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (capture) begin
      q_neg_q <= b_neg ^ d_neg;
      r_neg_q <= b_neg;
    end
  end
`else
  assign cap_err = bus.sw == '0;
  assign cap_d   = bus.sw;
  assign cap_a   = cap_err ? b_q : '0;
  assign cap_b   = cap_err ? '1 : b_q;
  assign fix_a   = a_q;
  assign fix_b   = b_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      d_q <= '0;
      x_q <= 1'b0;
    end else if (ld_b) begin
      a_q <= '0;
      b_q <= bus.sw;
      x_q <= 1'b0;
    end else if (capture) begin
      d_q <= cap_d;
      a_q <= cap_a;
      b_q <= cap_b;
      x_q <= cap_err;
    end else if (shift_sub) begin
      a_q <= ge ? a_sub : t[WIDTH-1:0];
      b_q <= {b_q[WIDTH-2:0], ge};
    end else if (fix) begin
      a_q <= fix_a;
      b_q <= fix_b;
    end
  end

  HexDriver u_hex_au (.in_i(a_q[7:4]), .out_o(ahex_u));
  HexDriver u_hex_al (.in_i(a_q[3:0]), .out_o(ahex_l));
  HexDriver u_hex_bu (.in_i(b_q[7:4]), .out_o(bhex_u));
  HexDriver u_hex_bl (.in_i(b_q[3:0]), .out_o(bhex_l));

  assign bus.x      = x_q;
  assign bus.aval   = a_q;
  assign bus.bval   = b_q;
  assign bus.ahex_u = ahex_u;
  assign bus.ahex_l = ahex_l;
  assign bus.bhex_u = bhex_u;
  assign bus.bhex_l = bhex_l;
endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed and random divisions against an arithmetic model.
module tb_divider;
  import divider_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] mb;

`ifdef DIVIDER_SIGNED_EN
  localparam int LAT_N = 11;
`else
  localparam int LAT_N = 10;
`endif
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  divider_if bus ();
  divider dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic ref_div(input logic [7:0] n, input logic [7:0] dv,
                         output logic [7:0] q, output logic [7:0] r, output logic xe);
`ifdef DIVIDER_SIGNED_EN
    int sn = int'($signed(n));
    int sd = int'($signed(dv));
    if (sd == 0) begin
      q = 8'hFF; r = n; xe = 1'b1;
    end else if (sn == -128 && sd == -1) begin
      q = 8'h80; r = 8'h00; xe = 1'b1;
    end else begin
      q = 8'(sn / sd); r = 8'(sn % sd); xe = 1'b0;
    end
`else
    int un = int'(n);
    int ud = int'(dv);
    if (ud == 0) begin
      q = 8'hFF; r = n; xe = 1'b1;
    end else begin
      q = 8'(un / ud); r = 8'(un % ud); xe = 1'b0;
    end
`endif
  endtask

  task automatic check_all(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                           input logic ex);
    chk({tag, "_aval"}, bus.aval, ea);
    chk({tag, "_bval"}, bus.bval, eb);
    chk({tag, "_x"}, {7'd0, bus.x}, {7'd0, ex});
    chk({tag, "_ahexu"}, {1'b0, bus.ahex_u}, {1'b0, GLYPH[ea[7:4]]});
    chk({tag, "_ahexl"}, {1'b0, bus.ahex_l}, {1'b0, GLYPH[ea[3:0]]});
    chk({tag, "_bhexu"}, {1'b0, bus.bhex_u}, {1'b0, GLYPH[eb[7:4]]});
    chk({tag, "_bhexl"}, {1'b0, bus.bhex_l}, {1'b0, GLYPH[eb[3:0]]});
  endtask

  task automatic do_load(input logic [7:0] v);
    bus.clear_a_load_b = 1'b1;
    bus.sw = v;
    step();
    bus.clear_a_load_b = 1'b0;
    mb = v;
  endtask

  task automatic do_div(input string tag, input logic [7:0] dvs);
    logic [7:0] q, r;
    logic xe;
    ref_div(mb, dvs, q, r, xe);
    bus.run = 1'b1;
    bus.sw = dvs;
    repeat (xe ? 2 : LAT_N) step();
    check_all(tag, r, q, xe);
    bus.run = 1'b0;
    repeat (2) step();
    mb = q;
  endtask

  initial begin
    logic [7:0] q, r, dv;
    logic xe;
    bus.clear_a_load_b = 1'b0;
    bus.run = 1'b0;
    bus.sw = 8'h00;
    mb = 8'h00;
    repeat (2) step();
    rst = 1'b0;
    step();

    // 1: reset in idle after a load
    do_load(8'h5A);
    chk("load_b", bus.bval, 8'h5A);
    rst = 1'b1;
    repeat (2) step();
    check_all("reset", 8'h00, 8'h00, 1'b0);
    chk("reset_glyph", {1'b0, bus.ahex_u}, {1'b0, SEG_ZERO});
    rst = 1'b0;
    step();
    mb = 8'h00;

    // 2..4: directed divisions, divide by zero, chaining
    do_load(8'h64);
    do_div("d100_7", 8'h07);
    do_load(8'h2A);
    do_div("dz", 8'h00);
    do_load(8'h11);
    check_all("load_clr_x", 8'h00, 8'h11, 1'b0);
    do_load(8'h05);
    do_div("d5_9", 8'h09);
    do_load(8'hFF);
    do_div("chain1", 8'h01);
    do_div("chain2", 8'h02);

    // 5: reset during the fourth iteration
    do_load(8'h9B);
    bus.run = 1'b1;
    bus.sw = 8'h05;
    repeat (5) step();
    rst = 1'b1;
    #1;
    check_all("mid_rst", 8'h00, 8'h00, 1'b0);
    bus.run = 1'b0;
    step();
    rst = 1'b0;
    step();
    mb = 8'h00;
    do_load(8'hC8);
    do_div("post_rst", 8'h03);

    // 6: run held long with a load pulse during ITER
    do_load(8'hD7);
    ref_div(mb, 8'h0B, q, r, xe);
    bus.run = 1'b1;
    bus.sw = 8'h0B;
    repeat (3) step();
    bus.clear_a_load_b = 1'b1;
    bus.sw = 8'h55;
    step();
    bus.clear_a_load_b = 1'b0;
    bus.sw = 8'h0B;
    repeat (26) step();
    check_all("held_run", r, q, xe);
    bus.run = 1'b0;
    repeat (2) step();
    check_all("held_after", r, q, xe);
    mb = q;

`ifdef DIVIDER_SIGNED_EN
    // 7: signed cases
    do_load(8'hF9);
    do_div("s_f9_2", 8'h02);
    chk("s_f9_2_q_const", bus.bval, 8'hFD);
    chk("s_f9_2_r_const", bus.aval, 8'hFF);
    do_load(8'h80);
    do_div("s_ovf", 8'hFF);
    chk("s_ovf_q_const", bus.bval, 8'h80);
    chk("s_ovf_x_const", {7'd0, bus.x}, 8'h01);
`endif

    // random load/divide pairs, roughly one in six by zero
    for (int i = 0; i < 16; i++) begin
      do_load(8'($urandom));
      dv = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      do_div($sformatf("rnd%0d", i), dv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
